// File: rtl/i2c_master_byte_ctrl.sv
// I2C master byte controller.
// Sequences one byte command (optional START, WRITE or READ of DW bits,
// ACK phase, optional STOP) into bit commands for a single bit controller.
// Data is shifted MSB-first through one shift register that serves both
// directions. An arbitration loss aborts the byte without a cmd_ack.
module i2c_master_byte_ctrl #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          nReset,
   input  logic          start,
   input  logic          stop,
   input  logic          read,
   input  logic          write,
   input  logic          ack_in,
   input  logic [DW-1:0] din,
   output logic          cmd_ack,
   output logic          ack_out,
   output logic [DW-1:0] dout,
   output logic          busy,
   output logic          i2c_al,
   output logic [3:0]    bit_cmd,
   input  logic          bit_ack,
   input  logic          bit_al,
   output logic          bit_din,
   input  logic          bit_dout
);

   // Bit controller command codes
   localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
   localparam logic [3:0] I2C_CMD_START = 4'b0001;
   localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
   localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
   localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

   localparam int             CW      = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(DW - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WRITE,
      ST_READ,
      ST_ACK,
      ST_STOP
   } state_t;

   state_t        state;
   logic [DW-1:0] sr;
   logic [CW-1:0] bitcnt;
   logic          go;

   // A held command is masked during the cmd_ack cycle so the host can drop it
   assign go   = (read | write | stop) & ~cmd_ack;
   assign dout = sr;
   assign busy = (state != ST_IDLE);

   // The ACK phase drives the host's ACK value; otherwise the current MSB
   assign bit_din = (state == ST_ACK) ? ack_in : sr[DW-1];

   // Registered copy of the bit controller's arbitration-lost flag
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) i2c_al <= 1'b0;
      else         i2c_al <= bit_al;
   end

   // Byte sequencer: state, bit command, shift register, bit counter, handshakes
   always_ff @(posedge clk or negedge nReset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // branch below reads the pre-edge values of state, sr and bitcnt.
      if (!nReset) begin
         state   <= ST_IDLE;
         bit_cmd <= I2C_CMD_NOP;
         cmd_ack <= 1'b0;
         ack_out <= 1'b0;
         sr      <= '0;
         bitcnt  <= '0;
      end else if (bit_al) begin
         // Arbitration loss overrides everything, including a coincident bit_ack;
         // ack_out and sr keep their values for the host to inspect.
         state   <= ST_IDLE;
         bit_cmd <= I2C_CMD_NOP;
         cmd_ack <= 1'b0;
         bitcnt  <= '0;
      end else begin
         cmd_ack <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (go) begin
                  sr     <= din;
                  bitcnt <= CNT_MAX;
                  if (start) begin
                     state   <= ST_START;
                     bit_cmd <= I2C_CMD_START;
                  end else if (read) begin
                     state   <= ST_READ;
                     bit_cmd <= I2C_CMD_READ;
                  end else if (write) begin
                     state   <= ST_WRITE;
                     bit_cmd <= I2C_CMD_WRITE;
                  end else begin
                     state   <= ST_STOP;
                     bit_cmd <= I2C_CMD_STOP;
                  end
               end
            end

            ST_START: begin
               if (bit_ack) begin
                  bitcnt <= CNT_MAX;
                  if (read) begin
                     state   <= ST_READ;
                     bit_cmd <= I2C_CMD_READ;
                  end else begin
                     state   <= ST_WRITE;
                     bit_cmd <= I2C_CMD_WRITE;
                  end
               end
            end

            ST_WRITE, ST_READ: begin
               if (bit_ack) begin
                  sr <= {sr[DW-2:0], bit_dout};
                  if (bitcnt == '0) begin
                     // After a write the slave's ACK is sampled; after a read ack_in is driven
                     state   <= ST_ACK;
                     bit_cmd <= (state == ST_WRITE) ? I2C_CMD_READ : I2C_CMD_WRITE;
                  end else begin
                     bitcnt <= bitcnt - 1'b1;
                  end
               end
            end

            ST_ACK: begin
               if (bit_ack) begin
                  ack_out <= bit_dout;
                  if (stop) begin
                     state   <= ST_STOP;
                     bit_cmd <= I2C_CMD_STOP;
                  end else begin
                     state   <= ST_IDLE;
                     bit_cmd <= I2C_CMD_NOP;
                     cmd_ack <= 1'b1;
                  end
               end
            end

            ST_STOP: begin
               if (bit_ack) begin
                  state   <= ST_IDLE;
                  bit_cmd <= I2C_CMD_NOP;
                  cmd_ack <= 1'b1;
               end
            end

            default: begin
               state   <= ST_IDLE;
               bit_cmd <= I2C_CMD_NOP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Testbench for i2c_master_byte_ctrl: a bit-controller model checks each
// bit command against a queue of expected commands, and a monitor checks
// each cmd_ack against a queue of expected byte results.
module tb_i2c_master_byte_ctrl;

   localparam logic [3:0] C_NOP   = 4'b0000;
   localparam logic [3:0] C_START = 4'b0001;
   localparam logic [3:0] C_STOP  = 4'b0010;
   localparam logic [3:0] C_WRITE = 4'b0100;
   localparam logic [3:0] C_READ  = 4'b1000;

   // kind: 0 = normal bit_ack, 1 = arbitration loss, 2 = async reset mid-bit
   typedef struct {
      logic [3:0] cmd;
      logic       care;
      logic       din;
      logic       rsp;
      int         kind;
   } bit_t;

   typedef struct {
      logic       ack;
      logic [7:0] dout;
   } byte_t;

   logic       clk = 1'b0;
   logic       nReset = 1'b0;
   logic       start = 1'b0, stop = 1'b0, read = 1'b0, write = 1'b0, ack_in = 1'b0;
   logic [7:0] din = '0;
   logic       cmd_ack, ack_out, busy, i2c_al, bit_din;
   logic [7:0] dout;
   logic [3:0] bit_cmd;
   logic       bit_ack = 1'b0, bit_al = 1'b0, bit_dout = 1'b0;

   bit_t  bit_q[$];
   byte_t byte_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    aborted = 1'b0;

   always #5 clk = ~clk;

   i2c_master_byte_ctrl #(.DW(8)) dut (
      .clk(clk), .nReset(nReset), .start(start), .stop(stop), .read(read),
      .write(write), .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack),
      .ack_out(ack_out), .dout(dout), .busy(busy), .i2c_al(i2c_al),
      .bit_cmd(bit_cmd), .bit_ack(bit_ack), .bit_al(bit_al),
      .bit_din(bit_din), .bit_dout(bit_dout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_bit(input logic [3:0] cmd, input logic care, input logic d,
                           input logic rsp, input int kind);
      bit_t e;
      e.cmd = cmd; e.care = care; e.din = d; e.rsp = rsp; e.kind = kind;
      bit_q.push_back(e);
   endtask

   task automatic push_byte(input logic ack, input logic [7:0] d);
      byte_t b;
      b.ack = ack; b.dout = d;
      byte_q.push_back(b);
   endtask

   // Write bits MSB-first; the bus echoes each written bit back on bit_dout
   task automatic push_write_bits(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) push_bit(C_WRITE, 1'b1, d[i], d[i], 0);
   endtask

   // Host: present a command, hold it until cmd_ack (or the abort), then drop it
   task automatic run_cmd(input logic s, input logic p, input logic r, input logic w,
                          input logic ai, input logic [7:0] d, input bit abort);
      bit done = 1'b0;
      @(negedge clk);
      start = s; stop = p; read = r; write = w; ack_in = ai; din = d;
      @(negedge clk);
      check("busy_after_accept", busy, 1);
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (!abort && cmd_ack) begin
            done = 1'b1;
            check("busy_at_cmd_ack", busy, 0);
            check("bit_cmd_nop_at_cmd_ack", bit_cmd, C_NOP);
            check("bit_cmds_all_issued", bit_q.size(), 0);
         end else if (abort && aborted) begin
            done = 1'b1;
            aborted = 1'b0;
         end
      end
      if (!done) check("cmd_timeout", 0, 1);
      start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
   endtask

   // Bit controller model: checks each new bit command, then answers it
   initial begin : bit_model
      bit_t e;
      forever begin
         @(negedge clk);
         if (bit_cmd != C_NOP) begin
            if (bit_q.size() == 0) begin
               check("unexpected_bit_cmd", bit_cmd, C_NOP);
               e.cmd = bit_cmd; e.care = 1'b0; e.din = 1'b0; e.rsp = 1'b0; e.kind = 0;
            end else begin
               e = bit_q.pop_front();
               check("bit_cmd", bit_cmd, e.cmd);
               if (e.care) check("bit_din", bit_din, e.din);
            end
            if (e.kind == 2) begin
               @(negedge clk);
               #2 nReset = 1'b0;
               #1;
               check("rst_bit_cmd", bit_cmd, C_NOP);
               check("rst_busy", busy, 0);
               check("rst_cmd_ack", cmd_ack, 0);
               aborted = 1'b1;
               @(negedge clk);
               #1 nReset = 1'b1;
            end else begin
               repeat (2) @(negedge clk);
               if (e.kind == 1) begin
                  bit_al = 1'b1;
                  bit_ack = 1'b1;   // coincident bit_ack must lose to bit_al
                  bit_dout = e.rsp;
                  @(posedge clk);
                  #1 aborted = 1'b1;
                  @(negedge clk);
                  bit_al = 1'b0; bit_ack = 1'b0;
                  check("al_busy", busy, 0);
                  check("al_bit_cmd", bit_cmd, C_NOP);
                  check("al_i2c_al", i2c_al, 1);
               end else begin
                  bit_ack = 1'b1;
                  bit_dout = e.rsp;
                  @(negedge clk);
                  bit_ack = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: every cmd_ack pulse must match the next expected byte result
   initial begin : monitor
      byte_t b;
      bit    prev = 1'b0;
      forever begin
         @(negedge clk);
         if (prev) check("cmd_ack_one_cycle", cmd_ack, 0);
         if (cmd_ack) begin
            if (byte_q.size() == 0) begin
               check("unexpected_cmd_ack", cmd_ack, 0);
            end else begin
               b = byte_q.pop_front();
               check("ack_out", ack_out, b.ack);
               check("dout", dout, b.dout);
            end
         end
         prev = cmd_ack;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      #12;
      check("reset_bit_cmd", bit_cmd, C_NOP);
      check("reset_cmd_ack", cmd_ack, 0);
      check("reset_ack_out", ack_out, 0);
      check("reset_i2c_al", i2c_al, 0);
      check("reset_dout", dout, 8'h00);
      check("reset_busy", busy, 0);
      nReset = 1'b1;
      repeat (2) @(negedge clk);

      // 1: START + write A5, slave ACKs
      push_bit(C_START, 1'b0, 1'b0, 1'b0, 0);
      push_write_bits(8'hA5);
      push_bit(C_READ, 1'b0, 1'b0, 1'b0, 0);
      push_byte(1'b0, 8'hA5);
      run_cmd(1, 0, 0, 1, 0, 8'hA5, 0);

      // 2: read C3 (1,1,0,0,0,0,1,1), NACK, STOP
      push_bit(C_READ, 1'b0, 1'b0, 1'b1, 0);
      push_bit(C_READ, 1'b0, 1'b0, 1'b1, 0);
      push_bit(C_READ, 1'b0, 1'b0, 1'b0, 0);
      push_bit(C_READ, 1'b0, 1'b0, 1'b0, 0);
      push_bit(C_READ, 1'b0, 1'b0, 1'b0, 0);
      push_bit(C_READ, 1'b0, 1'b0, 1'b0, 0);
      push_bit(C_READ, 1'b0, 1'b0, 1'b1, 0);
      push_bit(C_READ, 1'b0, 1'b0, 1'b1, 0);
      push_bit(C_WRITE, 1'b1, 1'b1, 1'b1, 0);
      push_bit(C_STOP, 1'b0, 1'b0, 1'b0, 0);
      push_byte(1'b1, 8'hC3);
      run_cmd(0, 1, 1, 0, 1, 8'h00, 0);

      // 3: STOP only; sr is loaded from din, ack_out keeps the NACK
      push_bit(C_STOP, 1'b0, 1'b0, 1'b0, 0);
      push_byte(1'b1, 8'h5A);
      run_cmd(0, 1, 0, 0, 0, 8'h5A, 0);

      // 4: write 00, slave NACKs
      push_write_bits(8'h00);
      push_bit(C_READ, 1'b0, 1'b0, 1'b1, 0);
      push_byte(1'b1, 8'h00);
      run_cmd(0, 0, 0, 1, 0, 8'h00, 0);

      // 5: write F0, arbitration lost on the 4th bit; sr holds F0<<3|111 = 87
      push_bit(C_WRITE, 1'b1, 1'b1, 1'b1, 0);
      push_bit(C_WRITE, 1'b1, 1'b1, 1'b1, 0);
      push_bit(C_WRITE, 1'b1, 1'b1, 1'b1, 0);
      push_bit(C_WRITE, 1'b1, 1'b1, 1'b1, 1);
      run_cmd(0, 0, 0, 1, 0, 8'hF0, 1);
      check("al_dout_held", dout, 8'h87);
      check("al_ack_out_held", ack_out, 1);

      // 6: next write is accepted normally, slave ACKs
      push_write_bits(8'h3C);
      push_bit(C_READ, 1'b0, 1'b0, 1'b0, 0);
      push_byte(1'b0, 8'h3C);
      run_cmd(0, 0, 0, 1, 0, 8'h3C, 0);

      // 7: async reset during the 3rd READ bit
      push_bit(C_READ, 1'b0, 1'b0, 1'b1, 0);
      push_bit(C_READ, 1'b0, 1'b0, 1'b0, 0);
      push_bit(C_READ, 1'b0, 1'b0, 1'b1, 2);
      run_cmd(0, 0, 1, 0, 0, 8'hFF, 1);
      check("post_rst_dout", dout, 8'h00);
      check("post_rst_ack_out", ack_out, 0);
      check("post_rst_i2c_al", i2c_al, 0);

      // 8: START + write 96 after reset
      push_bit(C_START, 1'b0, 1'b0, 1'b0, 0);
      push_write_bits(8'h96);
      push_bit(C_READ, 1'b0, 1'b0, 1'b0, 0);
      push_byte(1'b0, 8'h96);
      run_cmd(1, 0, 0, 1, 0, 8'h96, 0);

      repeat (10) @(negedge clk);
      check("final_busy", busy, 0);
      check("bit_q_empty", bit_q.size(), 0);
      check("byte_q_empty", byte_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_master_byte_ctrl.md
Name: i2c_master_byte_ctrl

Overview:
- Byte-level sequencer that sits directly above the I2C bit controller.
- Turns one byte command (optional START, WRITE or READ of DW bits, ACK phase, optional STOP) into a series of bit commands: START 4'b0001, STOP 4'b0010, WRITE 4'b0100, READ 4'b1000, NOP 4'b0000.
- Shifts data in and out MSB-first, captures the ACK bit, and aborts on arbitration loss.
- Driven by the register/host interface; drives exactly one bit controller.

Parameters:
DW, 8, data width per transfer (bits shifted between ACK phases)

Ports:
clk  in  1  system clock, all logic on rising edge
nReset  in  1  asynchronous active-low reset
start  in  1  issue START before the data phase
stop  in  1  issue STOP after the ACK phase (alone: STOP only)
read  in  1  read DW bits from the bus
write  in  1  write din to the bus
ack_in  in  1  ACK value driven after a read (0=ACK, 1=NACK)
din  in  DW  write data, sampled when a command is accepted
cmd_ack  out  1  one-cycle pulse: byte command complete
ack_out  out  1  ACK bit sampled in the ACK phase
dout  out  DW  shift register contents (read data)
busy  out  1  high whenever state != IDLE
i2c_al  out  1  registered copy of bit_al
bit_cmd  out  4  command to the bit controller
bit_ack  in  1  bit controller command-done pulse
bit_al  in  1  bit controller arbitration-lost
bit_din  out  1  bit value for the bit controller's WRITE
bit_dout  in  1  bit value sampled by the bit controller

Behaviour:
- Clock and reset: one clock (clk). Reset nReset is asynchronous, active-low. There is no synchronous reset.
- Reset values: state=IDLE, bit_cmd=NOP, cmd_ack=0, ack_out=0, i2c_al=0, sr=0, bitcnt=0, busy=0.
- Command acceptance: go = (read|write|stop) & ~cmd_ack. start alone is not a command. go is evaluated only in IDLE. The host holds command bits until cmd_ack.
- States: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE & go:
  - sr<=din, bitcnt<=DW-1.
  - Next state is the first of START, READ, WRITE, STOP whose enable is set (checked in that order).
  - bit_cmd takes the matching command code.
- START & bit_ack: bitcnt<=DW-1. Go to READ (bit_cmd=READ) if read, else WRITE (bit_cmd=WRITE).
- WRITE/READ & bit_ack:
  - sr<={sr[DW-2:0],bit_dout}.
  - If bitcnt==0: go to ACK. From WRITE, bit_cmd=READ (sample slave ACK). From READ, bit_cmd=WRITE (drive ack_in).
  - Else: bitcnt<=bitcnt-1 and the command repeats.
- ACK & bit_ack: ack_out<=bit_dout. If stop, go to STOP with bit_cmd=STOP. Else go to IDLE with bit_cmd=NOP and cmd_ack=1.
- STOP & bit_ack: go to IDLE, bit_cmd=NOP, cmd_ack=1.
- bit_din is combinational: ack_in in ACK, sr[DW-1] otherwise. The data bit therefore stays stable until the bit_ack that ends that bit.
- Update timing: bit_cmd and state update on the edge where bit_ack=1, so the new command is visible the cycle after bit_ack. bit_ack outside an active state is ignored.
- cmd_ack: high exactly one cycle. In that cycle go is masked, so a held command is not restarted until the host has had one cycle to drop it.
- Arbitration loss: i2c_al<=bit_al every cycle. When bit_al=1, in any state, the next edge sets state=IDLE, bit_cmd=NOP, cmd_ack=0, bitcnt=0. ack_out and sr hold their values. No cmd_ack is generated for the aborted byte.
- Simultaneous bit_al and bit_ack: bit_al wins.
- Reset mid-transfer: immediately returns all registers to reset values.
- dout = sr. Valid read data is present from the cmd_ack cycle onward, until the next accepted command.

Test Plan:
- Write with start: start=1, write=1, din=8'hA5; bench returns bit_ack after each command with bit_dout=0 in ACK → bit_cmd sequence START, WRITE×8, READ, NOP; bit_din at each WRITE = 1,0,1,0,0,1,0,1; ack_out=0; one cmd_ack pulse.
- Read with NACK and stop: read=1, stop=1, ack_in=1; bit_dout sequence 1,1,0,0,0,0,1,1 → READ×8, WRITE with bit_din=1, STOP, NOP; dout=8'hC3; cmd_ack after STOP's bit_ack only.
- Stop only: stop=1 → bit_cmd STOP then NOP, cmd_ack one cycle, busy high 1 cycle after acceptance until cmd_ack.
- Slave NACK on write: write=1, din=8'h00, bit_dout=1 in ACK → ack_out=1, cmd_ack=1, state IDLE.
- Arbitration loss: bit_al=1 during 4th WRITE bit → next cycle state IDLE, bit_cmd=NOP, i2c_al=1, no cmd_ack; subsequent write=1 accepted normally.
- Async reset: deassert nReset mid-READ between clock edges → bit_cmd=NOP, busy=0, cmd_ack=0 immediately, without waiting for a clock edge.
